// File: rtl/regfile_sweep.sv
// regfile_sweep: 2-read/1-write register file with post-reset clear sweep,
// hard-wired zero register, per-register pending (scoreboard) bits and
// optional same-cycle write-to-read bypass (macro REGFILE_BYPASS_EN).
// Ports: Clk, Reset (sync, active-high); RA/RB read addresses, RW/BusW/RegWr
// write port; ResvEn/ResvReg reserve port; BusA/BusB read data, BusyA/BusyB
// pending bits of RA/RB; Ready high once the clear sweep has finished.
module regfile_sweep #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   input  logic [ADDR_W-1:0] RW,
   input  logic [DATA_W-1:0] BusW,
   input  logic              RegWr,
   input  logic              ResvEn,
   input  logic [ADDR_W-1:0] ResvReg,
   output logic [DATA_W-1:0] BusA,
   output logic [DATA_W-1:0] BusB,
   output logic              BusyA,
   output logic              BusyB,
   output logic              Ready
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W:0]   LastIdx  = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t            stateQ, stateD;
   logic [ADDR_W:0]   cntQ, cntD;
   logic              sweepWr;
   logic              wrEn;
   logic              resvEn;
   logic [DATA_W-1:0] registers [DEPTH];
   logic [DEPTH-1:0]  pending;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stateQ <= CLEAR;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   always_comb begin
      stateD  = stateQ;
      cntD    = cntQ;
      sweepWr = 1'b0;
      unique case (stateQ)
         CLEAR: begin
            sweepWr = 1'b1;
            cntD    = cntQ + 1'b1;
            // Full-width compare: the extra counter bit prevents aliasing.
            if (cntQ == LastIdx) stateD = RUN;
         end
         RUN: begin
            cntD = cntQ;
         end
         default: stateD = CLEAR;
      endcase
   end

   assign wrEn   = (stateQ == RUN) && !Reset && RegWr && (RW != ZeroAddr);
   assign resvEn = (stateQ == RUN) && !Reset && ResvEn && (ResvReg != ZeroAddr);

   always_ff @(posedge Clk) begin
      if (sweepWr) begin
         registers[cntQ[ADDR_W-1:0]] <= '0;
      end else if (wrEn) begin
         registers[RW] <= BusW;
      end
   end

   // Reserve is applied after the write clear so a newer producer wins.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pending <= '0;
      end else begin
         if (wrEn) pending[RW] <= 1'b0;
         if (resvEn) pending[ResvReg] <= 1'b1;
      end
   end

   always_comb begin
      BusA  = '0;
      BusB  = '0;
      BusyA = 1'b0;
      BusyB = 1'b0;
      if (stateQ == RUN) begin
         if (RA != ZeroAddr) begin
            BusA  = registers[RA];
            BusyA = pending[RA];
`ifdef REGFILE_BYPASS_EN
            if (wrEn && (RW == RA)) begin
               BusA  = BusW;
               BusyA = 1'b0;
            end
`endif
         end
         if (RB != ZeroAddr) begin
            BusB  = registers[RB];
            BusyB = pending[RB];
`ifdef REGFILE_BYPASS_EN
            if (wrEn && (RW == RB)) begin
               BusB  = BusW;
               BusyB = 1'b0;
            end
`endif
         end
      end
   end

   assign Ready = (stateQ == RUN);

endmodule
